// File: rtl/rs232_rx.sv
// -----------------------------------------------------------------------------
// rs232_rx : 8N1 serial receiver for the RS232 DCE link.
//
// The line uses the same polarity as the matching transmitter. The line idles
// at 0 and the start bit is 1. The 8 data bits follow LSB first and are not
// inverted. The stop bit is 0. Each received byte is offered to the consumer
// through a valid/ready handshake.
//
// Parameters
//   baud  line rate in bits/s
//   mhz   clock frequency in MHz
//
// Ports
//   clock          in   1  system clock, rising edge
//   reset          in   1  asynchronous active-high reset
//   RS232_DCE_RXD  in   1  asynchronous serial input from the pin
//   rx_data        out  8  received byte, stable while rx_vld=1
//   rx_vld         out  1  byte available, held until accepted
//   rx_rdy         in   1  consumer ready; transfer when rx_vld & rx_rdy
//   frame_err      out  1  one-cycle pulse: stop bit sampled as 1
//   overrun        out  1  one-cycle pulse: unaccepted byte was overwritten
//
// Build option
//   RS232_RX_MAJORITY_EN : each sample is the 2-of-3 majority of the
//                          synchronised line over the last three cycles of
//                          the bit window. Interface and timing are unchanged.
// -----------------------------------------------------------------------------
module rs232_rx #(
  parameter int baud = 9600,
  parameter int mhz  = 50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       RS232_DCE_RXD,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  input  logic       rx_rdy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned BIT_PER   = (mhz * 1_000_000) / baud;
  localparam int unsigned HALF_PER  = BIT_PER / 2;
  localparam logic [31:0] BIT_LAST  = 32'(BIT_PER - 1);
  localparam logic [31:0] HALF_LAST = 32'(HALF_PER - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_vld_q, rx_vld_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        rxs;
  logic        samp;

  assign rxs = sync2_q;

`ifdef RS232_RX_MAJORITY_EN
  // hist_q[1] holds rxs from two cycles ago and hist_q[0] from one cycle ago.
  // The sample is taken at cnt == target. The vote then covers cnt = target-2,
  // target-1 and target.
  logic [1:0] hist_q, hist_d;

  assign hist_d = {hist_q[0], rxs};
  assign samp   = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) hist_q <= 2'b00;
    else       hist_q <= hist_d;
  end
`else
  assign samp = rxs;
`endif

  always_comb begin
    sync1_d     = RS232_DCE_RXD;
    sync2_d     = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_vld_d    = rx_vld_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (rx_vld_q && rx_rdy) rx_vld_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rxs) begin
          state_d = ST_START;
          cnt_d   = 32'd0;
        end
      end
      ST_START: begin
        // Confirm the start bit halfway through its period.
        // A short high glitch falls back to idle here.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = 32'd0;
          idx_d   = 3'd0;
          state_d = samp ? ST_DATA : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          shift_d[idx_q] = samp;
          cnt_d          = 32'd0;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = 32'd0;
          if (!samp) begin
            // A new byte always wins.
            // Overrun only fires when the old byte is not taken on this same edge.
            rx_data_d = shift_q;
            rx_vld_d  = 1'b1;
            overrun_d = rx_vld_q & ~rx_rdy;
            state_d   = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_BREAK: begin
        // Wait for the line to return low so a stuck-high line cannot look
        // like a stream of start bits.
        if (!rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= 32'd0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_vld_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_vld_q    <= rx_vld_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_vld    = rx_vld_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_rs232_rx.sv
// -----------------------------------------------------------------------------
// tb_rs232_rx : directed bench for rs232_rx.
//
// The bench runs with mhz=1 and baud=100000, so one bit lasts 10 clocks.
// Inputs are driven on the falling edge and outputs are checked on the
// falling edge. A small monitor counts handshakes, frame_err pulses and
// overrun pulses so that the directed steps can compare them to expected
// totals.
// -----------------------------------------------------------------------------
module tb_rs232_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       rdy;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  int         acc_cnt  = 0;
  logic [7:0] acc_data = 8'h00;
  int         ferr_cnt = 0;
  int         ovr_cnt  = 0;

`ifdef RS232_RX_MAJORITY_EN
  localparam logic [7:0] EXP_GLITCH = 8'h96;
`else
  localparam logic [7:0] EXP_GLITCH = 8'h69;
`endif

  rs232_rx #(.baud(100000), .mhz(1)) dut (
    .clock         (clk),
    .reset         (rst),
    .RS232_DCE_RXD (rxd),
    .rx_data       (rx_data),
    .rx_vld        (rx_vld),
    .rx_rdy        (rdy),
    .frame_err     (frame_err),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      if (rx_vld && rdy) begin
        acc_cnt  <= acc_cnt + 1;
        acc_data <= rx_data;
      end
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
      if (overrun)   ovr_cnt  <= ovr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one 10-cycle bit. With glitch set, cycle 5 is inverted.
  // Cycle 5 is the cycle the receiver samples.
  task automatic send_bit(input logic v, input bit glitch);
    for (int j = 0; j < 10; j++) begin
      rxd = (glitch && j == 5) ? ~v : v;
      @(negedge clk);
    end
  endtask

  task automatic send_head(input logic [7:0] d, input bit glitch);
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input bit glitch);
    send_head(d, glitch);
    send_bit(stop_v, 1'b0);
  endtask

  task automatic idle(input int n);
    rxd = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    rxd = 1'b0;
    rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_vld", 32'(rx_vld), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    idle(5);

    // Frame 0xA5 with the consumer ready. This step also checks exact latency.
    rdy = 1'b1;
    send_head(8'hA5, 1'b0);
    rxd = 1'b0;
    repeat (7) @(negedge clk);
    check("t1_vld_before_sample", 32'(rx_vld), 32'd0);
    @(negedge clk);
    check("t1_vld_rise", 32'(rx_vld), 32'd1);
    check("t1_data", 32'(rx_data), 32'hA5);
    @(negedge clk);
    check("t1_vld_one_cycle", 32'(rx_vld), 32'd0);
    @(negedge clk);
    idle(5);
    check("t1_acc_cnt", 32'(acc_cnt), 32'd1);
    check("t1_acc_data", 32'(acc_data), 32'hA5);
    check("t1_ferr", 32'(ferr_cnt), 32'd0);
    check("t1_ovr", 32'(ovr_cnt), 32'd0);

    // Two frames with no accept. The second overwrites the first and flags overrun.
    rdy = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(5);
    check("t2_vld_held", 32'(rx_vld), 32'd1);
    check("t2_data_first", 32'(rx_data), 32'h3C);
    check("t2_no_ovr_yet", 32'(ovr_cnt), 32'd0);
    send_frame(8'h81, 1'b0, 1'b0);
    idle(5);
    check("t2_data_second", 32'(rx_data), 32'h81);
    check("t2_vld_still", 32'(rx_vld), 32'd1);
    check("t2_ovr_once", 32'(ovr_cnt), 32'd1);
    rdy = 1'b1;
    @(negedge clk);
    check("t2_vld_cleared", 32'(rx_vld), 32'd0);
    check("t2_acc_cnt", 32'(acc_cnt), 32'd2);
    check("t2_acc_data", 32'(acc_data), 32'h81);

    // Bad stop bit followed by a stuck-high line, then a good frame.
    send_frame(8'h55, 1'b1, 1'b0);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    check("t3_ferr_once", 32'(ferr_cnt), 32'd1);
    check("t3_vld_low", 32'(rx_vld), 32'd0);
    check("t3_data_kept", 32'(rx_data), 32'h81);
    idle(10);
    check("t3_no_phantom", 32'(acc_cnt), 32'd2);
    send_frame(8'h12, 1'b0, 1'b0);
    idle(5);
    check("t3_acc_cnt", 32'(acc_cnt), 32'd3);
    check("t3_acc_data", 32'(acc_data), 32'h12);
    check("t3_ferr_total", 32'(ferr_cnt), 32'd1);

    // A 3-cycle high glitch on an idle line is rejected.
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    idle(25);
    check("t4_vld", 32'(rx_vld), 32'd0);
    check("t4_acc_cnt", 32'(acc_cnt), 32'd3);
    check("t4_ferr", 32'(ferr_cnt), 32'd1);

    // Reset during data bit 4. The partial byte must be discarded.
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    rxd = 1'b0;
    #1;
    check("t5_rst_vld", 32'(rx_vld), 32'd0);
    check("t5_rst_data", 32'(rx_data), 32'h00);
    check("t5_rst_ferr", 32'(frame_err), 32'd0);
    check("t5_rst_ovr", 32'(overrun), 32'd0);
    repeat (3) @(negedge clk);
    check("t5_rst_data_hold", 32'(rx_data), 32'h00);
    rst = 1'b0;
    idle(5);
    send_frame(8'hF0, 1'b0, 1'b0);
    idle(5);
    check("t5_acc_cnt", 32'(acc_cnt), 32'd4);
    check("t5_acc_data", 32'(acc_data), 32'hF0);
    check("t5_ferr", 32'(ferr_cnt), 32'd1);

    // 0x96 with a one-cycle inverted pulse at every data sample point.
    send_frame(8'h96, 1'b0, 1'b1);
    idle(5);
    check("t6_acc_cnt", 32'(acc_cnt), 32'd5);
    check("t6_glitch_data", 32'(acc_data), 32'(EXP_GLITCH));
    check("t6_ferr", 32'(ferr_cnt), 32'd1);
    check("t6_ovr", 32'(ovr_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
